// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl
// Game controller for the whack-a-mole display path with N_HOLES holes.
// It picks a pseudo-random hole, asks the box renderer to draw the mole,
// and times the hit window. A hit scores a point and a timeout counts as a
// miss. In both cases the controller then erases the mole and picks a new
// hole. The game ends when the score reaches WIN_SCORE.
//
// Optional build macro: WHACK_LIVES_EN
//   When defined, misses are counted (saturating at 3) and reaching
//   MAX_MISSES also ends the game. When undefined, misses reads 0.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       one-cycle pulse, starts a new game from IDLE or OVER
//   speed_sel   hit window select: 0 base, 1 x1.5, 2 x0.5, 3 x0.25
//   hit_valid   one-cycle pulse from the key decoder
//   hit_idx     hole index of the decoded key
//   plot_ack    one-cycle pulse, renderer finished the current request
//   plot_req    draw/erase request, held until plot_ack
//   plot_erase  1 = erase to background, 0 = draw mole
//   plot_idx    hole to draw/erase
//   score       current score (saturating)
//   game_over   high while in OVER
//   hit_pulse   one-cycle pulse on a successful hit
//   miss_pulse  one-cycle pulse on a window timeout
//   misses      miss count
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset, waiting for start
// PICK     | pick a random hole that differs from the previous one
// DRAW     | ask the renderer to draw the mole, wait for ack
// WAIT_HIT | hit window running
// HIT      | correct key seen, score a point
// MISS     | window expired
// ERASE    | ask the renderer to erase the mole, then check for game end
// OVER     | game finished, waiting for start
module whack_game_ctrl #(
  parameter int          N_HOLES    = 6,
  parameter int          SCORE_W    = 4,
  parameter int          WIN_SCORE  = 5,
  parameter int          T_BASE     = 50000000,
  parameter int          CNT_W      = 28,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MAX_MISSES = 3,
  localparam int         IDX_W      = (N_HOLES > 2) ? $clog2(N_HOLES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         speed_sel,
  input  logic               hit_valid,
  input  logic [IDX_W-1:0]   hit_idx,
  input  logic               plot_ack,
  output logic               plot_req,
  output logic               plot_erase,
  output logic [IDX_W-1:0]   plot_idx,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [1:0]         misses
);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_DRAW, S_WAIT_HIT, S_HIT, S_MISS, S_ERASE, S_OVER
  } state_t;

`ifdef WHACK_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] WIN_0 = CNT_W'(T_BASE);
  localparam logic [CNT_W-1:0] WIN_1 = CNT_W'(T_BASE + T_BASE / 2);
  localparam logic [CNT_W-1:0] WIN_2 = CNT_W'(T_BASE / 2);
  localparam logic [CNT_W-1:0] WIN_3 = CNT_W'(T_BASE / 4);
  localparam logic [IDX_W:0]   N_LIM = (IDX_W + 1)'(N_HOLES);
  localparam logic [15:0]      LFSR_MASK = 16'hB400;

  state_t             state_q, state_nxt;
  logic [15:0]        lfsr_q, lfsr_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   window_q, window_nxt, win_sel;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_nxt;
  logic [IDX_W-1:0]   prev_idx_q, prev_idx_nxt;
  logic [SCORE_W-1:0] score_q, score_nxt;
  logic [1:0]         misses_q, misses_nxt;
  logic [IDX_W-1:0]   cand;
  logic               cand_ok;
  logic               score_win;
  logic               miss_limit;

  // Galois shift right; feedback applied when the bit shifted out is 1.
  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // Out-of-range and repeated candidates are rejected; PICK retries with the
  // next LFSR value.
  assign cand    = lfsr_q[IDX_W-1:0];
  assign cand_ok = ({1'b0, cand} < N_LIM) && (cand != prev_idx_q);

  assign score_win  = (score_q >= SCORE_W'(WIN_SCORE));
  assign miss_limit = LIVES_EN && (int'(misses_q) >= MAX_MISSES);

  always_comb begin
    win_sel = WIN_0;
    case (speed_sel)
      2'd0: win_sel = WIN_0;
      2'd1: win_sel = WIN_1;
      2'd2: win_sel = WIN_2;
      2'd3: win_sel = WIN_3;
      default: win_sel = WIN_0;
    endcase
  end

  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    window_nxt   = window_q;
    cur_idx_nxt  = cur_idx_q;
    prev_idx_nxt = prev_idx_q;
    score_nxt    = score_q;
    misses_nxt   = misses_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_PICK;
          score_nxt    = '0;
          misses_nxt   = '0;
          prev_idx_nxt = '0;
        end
      end
      S_PICK: begin
        if (cand_ok) begin
          cur_idx_nxt = cand;
          window_nxt  = win_sel;
          state_nxt   = S_DRAW;
        end
      end
      S_DRAW: begin
        if (plot_ack) begin
          state_nxt = S_WAIT_HIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_HIT: begin
        cnt_nxt = cnt_q + 1'b1;
        // A correct hit on the timeout cycle takes priority over the miss.
        if (hit_valid && (hit_idx == cur_idx_q)) begin
          state_nxt = S_HIT;
        end else if (cnt_q == window_q - 1'b1) begin
          state_nxt = S_MISS;
        end
      end
      S_HIT: begin
        if (score_q != {SCORE_W{1'b1}}) begin
          score_nxt = score_q + 1'b1;
        end
        state_nxt = S_ERASE;
      end
      S_MISS: begin
        if (LIVES_EN && (misses_q != 2'd3)) begin
          misses_nxt = misses_q + 1'b1;
        end
        state_nxt = S_ERASE;
      end
      S_ERASE: begin
        if (plot_ack) begin
          prev_idx_nxt = cur_idx_q;
          state_nxt    = (score_win || miss_limit) ? S_OVER : S_PICK;
        end
      end
      S_OVER: begin
        if (start) begin
          state_nxt  = S_PICK;
          score_nxt  = '0;
          misses_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they belong to and stay glitch-free toward the renderer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      cnt_q      <= '0;
      window_q   <= '0;
      cur_idx_q  <= '0;
      prev_idx_q <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      plot_req   <= 1'b0;
      plot_erase <= 1'b0;
      plot_idx   <= '0;
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      lfsr_q     <= lfsr_nxt;
      cnt_q      <= cnt_nxt;
      window_q   <= window_nxt;
      cur_idx_q  <= cur_idx_nxt;
      prev_idx_q <= prev_idx_nxt;
      score_q    <= score_nxt;
      misses_q   <= misses_nxt;
      plot_req   <= (state_nxt == S_DRAW) || (state_nxt == S_ERASE);
      plot_erase <= (state_nxt == S_ERASE);
      plot_idx   <= cur_idx_nxt;
      game_over  <= (state_nxt == S_OVER);
      hit_pulse  <= (state_nxt == S_HIT);
      miss_pulse <= (state_nxt == S_MISS);
    end
  end

  assign score  = score_q;
  assign misses = misses_q;

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
- Parametrised game controller for the whack-a-mole display path. Generalises the fixed six-hole controller to N_HOLES holes.
- Provides a pseudo-random hole sequence, selectable hit windows, a handshaked plot interface to the VGA box renderer, and a configurable win score.
- Sits between the PS/2 key decoder, which supplies a hit index, and the box-drawing datapath.
- Score output feeds the existing hex display decoder.

Parameters:
- N_HOLES, 6, number of holes (2..16); IDX_W = clog2(N_HOLES), minimum 1.
- SCORE_W, 4, score width.
- WIN_SCORE, 5, score that ends the game (< 2^SCORE_W).
- T_BASE, 50000000, base hit window in clk cycles.
- CNT_W, 28, window counter width; must hold T_BASE*3/2.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.
- MAX_MISSES, 3, miss limit (used only with WHACK_LIVES_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new game from IDLE or OVER
- speed_sel  in  2  window select
- hit_valid  in  1  one-cycle pulse; key decoded to a hole
- hit_idx  in  IDX_W  hole index of the key
- plot_ack  in  1  renderer finished current request (one-cycle pulse)
- plot_req  out  1  draw/erase request, held until plot_ack
- plot_erase  out  1  1 = erase (background), 0 = draw mole
- plot_idx  out  IDX_W  hole to draw/erase
- score  out  SCORE_W  current score
- game_over  out  1  high in OVER
- hit_pulse  out  1  one-cycle pulse on a successful hit
- miss_pulse  out  1  one-cycle pulse on window timeout
- misses  out  2  miss count (constant 0 without WHACK_LIVES_EN)

Behaviour:
- Reset: state IDLE; plot_req=0, plot_erase=0, plot_idx=0, score=0, game_over=0, hit_pulse=0, miss_pulse=0, misses=0; lfsr=LFSR_SEED; window counter=0; prev_idx=0.
- LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400). Advances every clk cycle in every state except during reset.
- States and transitions:
  - IDLE: wait. start -> PICK; score, misses and prev_idx cleared.
  - PICK: cand = lfsr[IDX_W-1:0]. If cand < N_HOLES and cand != prev_idx: latch cur_idx=cand and latch the window from speed_sel, then -> DRAW. Otherwise stay in PICK (retry next cycle).
  - Window values by speed_sel: 0 -> T_BASE; 1 -> T_BASE + T_BASE/2; 2 -> T_BASE/2; 3 -> T_BASE/4. Integer division.
  - DRAW: plot_req=1, plot_erase=0, plot_idx=cur_idx. plot_ack -> WAIT_HIT; counter cleared. Hits in DRAW are ignored.
  - WAIT_HIT: counter increments each cycle.
    - hit_valid with hit_idx == cur_idx -> HIT.
    - hit_valid with the wrong idx is ignored.
    - Counter == window-1 with no valid hit that cycle -> MISS.
    - Hit and timeout in the same cycle: the hit wins.
  - HIT: hit_pulse=1 for one cycle. Score increments (saturating at 2^SCORE_W-1). -> ERASE.
  - MISS: miss_pulse=1 for one cycle. -> ERASE.
  - ERASE: plot_req=1, plot_erase=1, plot_idx=cur_idx. On plot_ack: prev_idx=cur_idx; if score >= WIN_SCORE -> OVER, else -> PICK.
  - OVER: game_over=1; plot_req=0. start -> PICK with score cleared and game_over dropped the next cycle.
- start outside IDLE/OVER is ignored.
- plot_req, plot_erase and plot_idx are registered outputs, stable while plot_req=1.
- plot_ack outside DRAW/ERASE is ignored.
- Reset asserted mid-request drops plot_req on the next edge; the renderer must tolerate an abandoned request.
- Latency: start -> plot_req is at least 2 cycles (PICK plus register), more if PICK retries.

Optional Feature:
- Macro: WHACK_LIVES_EN.
- Defined: misses increments in MISS (saturates at 3). At ERASE completion, if misses >= MAX_MISSES -> OVER; this win/lose check is evaluated together with the score check, and either condition goes to OVER. misses is cleared on start.
- Undefined: misses tied to 0; no miss limit; only WIN_SCORE ends the game.

Test Plan:
- Bench parameters: N_HOLES=6, T_BASE=20, WIN_SCORE=5, renderer acks 3 cycles after each req.
- Reset, then start -> plot_req rises with plot_erase=0 and plot_idx<6. Over the run, no two consecutive draws share the same idx.
- Correct hit 5 cycles into WAIT_HIT -> one hit_pulse; score 0->1; erase request for the same idx; then a new draw.
- No hit, speed_sel=0 -> miss_pulse exactly 20 cycles after entering WAIT_HIT; score unchanged. With speed_sel=1 -> 30 cycles; speed_sel=3 -> 5 cycles.
- Wrong-idx hit, then correct hit on the timeout cycle -> wrong hit ignored, hit wins, no miss_pulse.
- Five correct hits -> score=5, game_over=1 after the fifth erase ack, plot_req=0. start -> score=0, game_over=0, new draw.
- With WHACK_LIVES_EN and MAX_MISSES=3: three timeouts -> misses=3, game_over=1, score=0. Reset asserted during DRAW -> all outputs return to reset values on the next edge.
